// File: rtl/fft_stage_controller.sv
// ============================================================================
// fft_stage_controller
//   Sequences a shared radix-2 butterfly over an in-place N-point DIT FFT.
//   Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_stage_controller #(
  parameter int LOG2N        = 4,
  parameter int BFLY_LATENCY = 3,
  parameter int RD_LATENCY   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  output logic [LOG2N-1:0] o_stage,
  output logic             o_rd_en,
  output logic [LOG2N-1:0] o_rd_addr_a,
  output logic [LOG2N-1:0] o_rd_addr_b,
  output logic [LOG2N-2:0] o_tw_addr,
  output logic             o_wr_en,
  output logic [LOG2N-1:0] o_wr_addr_a,
  output logic [LOG2N-1:0] o_wr_addr_b
);

  localparam int D  = RD_LATENCY + BFLY_LATENCY;
  localparam int DW = (D > 1) ? $clog2(D) : 1;
  localparam logic [LOG2N-2:0] K_LAST = '1;
  localparam logic [LOG2N-1:0] S_LAST = LOG2N'(LOG2N - 1);
  localparam logic [DW-1:0]    D_LAST = DW'(D - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t           state, state_n;
  logic [LOG2N-2:0] k, k_n;
  logic [LOG2N-1:0] s, s_n;
  logic [DW-1:0]    dcnt, dcnt_n;
  logic             rd_n;
  logic [LOG2N-1:0] kx, half, a_n, b_n;
  logic [LOG2N-2:0] pos, tw_n;

  always_comb begin
    state_n = state;
    k_n     = k;
    s_n     = s;
    dcnt_n  = dcnt;
    case (state)
      IDLE: begin
        if (i_start) begin
          state_n = READ;
          k_n     = '0;
          s_n     = '0;
        end
      end
      READ: begin
        if (k == K_LAST) begin
          state_n = DRAIN;
          dcnt_n  = '0;
        end else begin
          k_n = k + 1'b1;
        end
      end
      DRAIN: begin
        // Leave DRAIN on the cycle the stage's last write is on the port.
        if (dcnt == D_LAST) begin
          if (s == S_LAST) begin
            state_n = DONE;
          end else begin
            state_n = READ;
            s_n     = s + 1'b1;
            k_n     = '0;
          end
        end else begin
          dcnt_n = dcnt + 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    rd_n = (state_n == READ);

    // Insert a zero bit at position s of k to get the upper operand address.
    kx   = {1'b0, k_n};
    half = {{(LOG2N-1){1'b0}}, 1'b1} << s_n;
    pos  = k_n & (half[LOG2N-2:0] - 1'b1);
    a_n  = ((kx >> s_n) << (s_n + 1'b1)) | {1'b0, pos};
    b_n  = a_n + half;
    tw_n = pos << (S_LAST - s_n);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      k           <= '0;
      s           <= '0;
      dcnt        <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_stage     <= '0;
      o_rd_en     <= 1'b0;
      o_rd_addr_a <= '0;
      o_rd_addr_b <= '0;
      o_tw_addr   <= '0;
    end else begin
      state   <= state_n;
      k       <= k_n;
      s       <= s_n;
      dcnt    <= dcnt_n;
      o_busy  <= (state_n != IDLE);
      o_done  <= (state_n == DONE);
      o_stage <= (state_n == IDLE) ? '0 : s_n;
      o_rd_en <= rd_n;
      if (rd_n) begin
        o_rd_addr_a <= a_n;
        o_rd_addr_b <= b_n;
      end
      o_tw_addr <= rd_n ? tw_n : '0;
    end
  end

  logic [D-1:0]     en_pipe;
  logic [LOG2N-1:0] wa_pipe [D];
  logic [LOG2N-1:0] wb_pipe [D];

  // Write-back delay line matched to the read plus butterfly latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_pipe <= '0;
      for (int i = 0; i < D; i++) begin
        wa_pipe[i] <= '0;
        wb_pipe[i] <= '0;
      end
    end else begin
      en_pipe[0] <= o_rd_en;
      wa_pipe[0] <= o_rd_addr_a;
      wb_pipe[0] <= o_rd_addr_b;
      for (int i = 1; i < D; i++) begin
        en_pipe[i] <= en_pipe[i-1];
        wa_pipe[i] <= wa_pipe[i-1];
        wb_pipe[i] <= wb_pipe[i-1];
      end
    end
  end

  assign o_wr_en     = en_pipe[D-1];
  assign o_wr_addr_a = wa_pipe[D-1];
  assign o_wr_addr_b = wb_pipe[D-1];

endmodule

`default_nettype wire
